fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, meaning: PC and IRAM address width.
REQ-002 Parameter OP_NOP, default 8'd2, meaning: end-of-program opcode.
REQ-003 Parameter OP_JUMP, default 8'd29, meaning: unconditional jump opcode.
REQ-004 Parameter OP_JMPZ, default 8'd32, meaning: jump-if-Z opcode.
REQ-005 Parameter OP_JMNZ, default 8'd37, meaning: jump-if-not-Z opcode.
REQ-006 The port list SHALL include: clk  in  1  sole clock, rising edge.
REQ-007 The port list SHALL include: rst  in  1  asynchronous, active-high reset.
REQ-008 The port list SHALL include: iram_addr  out  8  read address to instruction RAM (synchronous read, 1-cycle latency).
REQ-009 The port list SHALL include: iram_dout  in  8  instruction RAM read data.
REQ-010 The port list SHALL include: z_flag  in  1  ALU zero flag, stable while the fetch unit resolves a branch.
REQ-011 The port list SHALL include: instr  out  8  opcode presented to the control unit.
REQ-012 The port list SHALL include: instr_valid  out  1  instr holds a valid opcode.
REQ-013 The port list SHALL include: instr_ready  in  1  control unit has finished the presented opcode.
REQ-014 The port list SHALL include: pc  out  8  current program counter.
REQ-015 The port list SHALL include: halted  out  1  NOP fetched; fetching stopped.
REQ-016 The port list SHALL include: retired  out  16  count of completed handshakes plus resolved jumps.

Function
REQ-017 The FSM SHALL have the states S_ADDR, S_DATA, S_PRESENT, S_OP_ADDR, S_OP_DATA and S_HALT.
REQ-018 iram_addr SHALL equal the pc register in every state; pc SHALL increment modulo 256 (8'd255+1 -> 8'd0).
REQ-019 S_ADDR SHALL unconditionally go to S_DATA.
REQ-020 In S_DATA: opcode = iram_dout; pc <= pc+1.
REQ-021 From S_DATA, JUMP, JMPZ or JMNZ SHALL go to S_OP_ADDR, with the opcode held internally and not presented.
REQ-022 From S_DATA, OP_NOP SHALL go to S_HALT.
REQ-023 From S_DATA, any other opcode SHALL be registered to instr, and the FSM SHALL go to S_PRESENT.
REQ-024 In S_PRESENT: instr_valid=1; instr SHALL remain stable until instr_ready=1, then the FSM SHALL go to S_ADDR.
REQ-025 Latency: instr_valid SHALL assert 2 cycles after entry to S_ADDR; the minimum opcode-to-opcode period is 3 cycles.
REQ-026 instr_ready SHALL be ignored outside S_PRESENT; instr_valid SHALL be 0 outside S_PRESENT.
REQ-027 S_OP_ADDR SHALL go to S_OP_DATA.
REQ-028 In S_OP_DATA: target = iram_dout; taken = JUMP | (JMPZ & z_flag) | (JMNZ & ~z_flag); pc <= taken ? target : pc+1; the FSM SHALL go to S_ADDR.
REQ-029 z_flag SHALL be sampled only in S_OP_DATA.
REQ-030 A jump whose target equals its own opcode address SHALL loop legally, with no hang detection.
REQ-031 S_HALT: halted=1, pc frozen at the NOP address+1; the FSM SHALL leave S_HALT only on reset.
REQ-032 retired SHALL increment on each S_PRESENT handshake and each S_OP_DATA cycle, saturating at 16'hFFFF.
REQ-033 A handshake and a jump resolution SHALL never coincide, since they occur in different states.

Reset
REQ-034 rst=1 SHALL asynchronously force state=S_ADDR, pc=0, instr=0, instr_valid=0, halted=0, retired=0.
REQ-035 Reset mid-operation (any state, including S_HALT or S_PRESENT awaiting ready) SHALL discard the pending opcode or operand.
REQ-036 After reset deassertion, the first IRAM read SHALL be address 0 on the next rising edge.

Structure
REQ-037 Opcode constants and FSM state encodings SHALL reside in the shared processor definitions package used by the control unit and the IRAM.
REQ-038 No sub-module SHALL be used; the PC, IR and operand registers SHALL be inline with the FSM.

Verification
REQ-039 Bench scenario: reset, IRAM[0]=7 (CLAC), ready held 1 -> instr=7, instr_valid high at cycle 2, pc=1, retired=1 after the handshake.
REQ-040 Bench scenario: ready delayed 5 cycles on opcode 19 -> instr stays 19, valid stays high, pc stays unchanged, no IRAM address change.
REQ-041 Bench scenario: IRAM[103]=32, [104]=120; z_flag=1 -> pc=120, no valid pulse for 32; z_flag=0 -> pc=105.
REQ-042 Bench scenario: IRAM[107]=37, [108]=21; z_flag=0 -> pc=21; z_flag=1 -> pc=109; IRAM[118]=29, [119]=21 -> pc=21 unconditionally.
REQ-043 Bench scenario: IRAM[120]=2 -> halted=1, pc=121, valid stays 0 for 20 cycles; rst pulse -> pc=0, halted=0.
REQ-044 Bench scenario: rst asserted in S_PRESENT and in S_OP_DATA -> outputs reach reset values immediately without a clock edge; pc 255 wraps to 0 on a non-jump opcode.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared processor definitions (opcodes, fetch FSM states).
package fetch_unit_pkg;
  localparam logic [7:0] OPC_NOP  = 8'd2;
  localparam logic [7:0] OPC_CLAC = 8'd7;
  localparam logic [7:0] OPC_JUMP = 8'd29;
  localparam logic [7:0] OPC_JMPZ = 8'd32;
  localparam logic [7:0] OPC_JMNZ = 8'd37;
  typedef enum logic [2:0] {
    S_ADDR, S_DATA, S_PRESENT, S_OP_ADDR, S_OP_DATA, S_HALT
  } fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM over a 1-cycle-latency IRAM; resolves jumps
// internally and presents all other opcodes to the control unit via valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] OP_NOP  = OPC_NOP,
  parameter logic [7:0] OP_JUMP = OPC_JUMP,
  parameter logic [7:0] OP_JMPZ = OPC_JMPZ,
  parameter logic [7:0] OP_JMNZ = OPC_JMNZ
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] iram_addr,
  input  logic [7:0]        iram_dout,
  input  logic              z_flag,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d, op_q, op_d;
  logic [15:0]       retired_q, retired_d;
  logic              is_jmp, is_nop, taken, retire;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_ADDR;
      pc_q      <= '0;
      instr_q   <= '0;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op_d    = op_q;
    is_jmp  = iram_dout == OP_JUMP || iram_dout == OP_JMPZ || iram_dout == OP_JMNZ;
    is_nop  = iram_dout == OP_NOP;
    // op_q holds the jump opcode while its operand is fetched; z_flag only matters in S_OP_DATA
    taken   = op_q == OP_JUMP || (op_q == OP_JMPZ && z_flag) || (op_q == OP_JMNZ && !z_flag);
    retire  = (state_q == S_PRESENT && instr_ready) || state_q == S_OP_DATA;
    retired_d = (retire && retired_q != 16'hFFFF) ? retired_q + 16'd1 : retired_q;
    case (state_q)
      S_ADDR:    state_d = S_DATA;
      S_DATA: begin
        pc_d    = pc_q + 1'b1;
        op_d    = iram_dout;
        instr_d = (is_jmp || is_nop) ? instr_q : iram_dout;
        state_d = is_jmp ? S_OP_ADDR : is_nop ? S_HALT : S_PRESENT;
      end
      S_PRESENT: state_d = instr_ready ? S_ADDR : S_PRESENT;
      S_OP_ADDR: state_d = S_OP_DATA;
      S_OP_DATA: begin
        pc_d    = taken ? ADDR_W'(iram_dout) : pc_q + 1'b1;
        state_d = S_ADDR;
      end
      default:   state_d = state_q;
    endcase
  end
  assign iram_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = state_q == S_PRESENT;
  assign halted      = state_q == S_HALT;
  assign retired     = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven branch vectors plus hand sequences, with a
// scoreboard of expected presented opcodes popped on each handshake.
module tb_fetch_unit;
  logic        clk = 0;
  logic        rst, z_flag, instr_ready, instr_valid, halted;
  logic [7:0]  iram_addr, iram_dout, instr, pc;
  logic [15:0] retired;
  logic [7:0]  mem [256];
  logic [7:0]  sb [$];
  logic        seen_valid;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [7:0] start;
    logic       z;
    logic [7:0] exp_pc;
  } vec_t;
  vec_t vecs [6];

  fetch_unit dut (
    .clk(clk), .rst(rst), .iram_addr(iram_addr), .iram_dout(iram_dout),
    .z_flag(z_flag), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) iram_dout <= mem[iram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (instr_valid) seen_valid = 1;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got opcode %0d expected none", instr);
      end else chk("sb_instr", 32'(instr), 32'(sb.pop_front()));
    end
  end

  initial begin
    int n;
    vecs[0] = '{8'd103, 1'b1, 8'd120};
    vecs[1] = '{8'd103, 1'b0, 8'd105};
    vecs[2] = '{8'd107, 1'b0, 8'd21};
    vecs[3] = '{8'd107, 1'b1, 8'd109};
    vecs[4] = '{8'd118, 1'b0, 8'd21};
    vecs[5] = '{8'd118, 1'b1, 8'd21};
    for (int i = 0; i < 256; i++) mem[i] = 8'd2;
    mem[103] = 8'd32; mem[104] = 8'd120;
    mem[107] = 8'd37; mem[108] = 8'd21;
    mem[118] = 8'd29; mem[119] = 8'd21;
    rst = 1; instr_ready = 0; z_flag = 0; seen_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retired", 32'(retired), 0);

    // basic fetch, then a held opcode, then NOP halt
    mem[0] = 8'd7; mem[1] = 8'd19; mem[2] = 8'd2;
    instr_ready = 1; sb.push_back(8'd7);
    rst = 0;
    @(negedge clk);
    chk("c1_valid", 32'(instr_valid), 0);
    chk("c1_addr", 32'(iram_addr), 0);
    @(negedge clk);
    chk("c2_valid", 32'(instr_valid), 1);
    chk("c2_instr", 32'(instr), 7);
    chk("c2_pc", 32'(pc), 1);
    @(negedge clk);
    chk("hs_retired", 32'(retired), 1);
    instr_ready = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_instr", 32'(instr), 19);
      chk("hold_valid", 32'(instr_valid), 1);
      chk("hold_pc", 32'(pc), 2);
      chk("hold_addr", 32'(iram_addr), 2);
      @(negedge clk);
    end
    instr_ready = 1; sb.push_back(8'd19);
    @(negedge clk);
    chk("hold_retired", 32'(retired), 2);
    repeat (2) @(negedge clk);
    chk("nop2_halted", 32'(halted), 1);
    chk("nop2_pc", 32'(pc), 3);

    // table-driven conditional/unconditional jumps entered via JUMP at 0
    foreach (vecs[v]) begin
      rst = 1;
      mem[0] = 8'd29; mem[1] = vecs[v].start;
      z_flag = vecs[v].z; instr_ready = 1;
      @(negedge clk);
      seen_valid = 0;
      rst = 0;
      n = 0;
      while (retired != 16'd2 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("vec%0d_timeout", v), 32'(n < 40), 1);
      chk($sformatf("vec%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
      chk($sformatf("vec%0d_novalid", v), 32'(seen_valid), 0);
    end

    // NOP at 120 halts, stays quiet, reset recovers
    rst = 1;
    mem[0] = 8'd29; mem[1] = 8'd120;
    @(negedge clk);
    rst = 0;
    n = 0;
    while (!halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("halt_timeout", 32'(n < 40), 1);
    chk("halt_pc", 32'(pc), 121);
    chk("halt_retired", 32'(retired), 1);
    seen_valid = 0;
    repeat (20) @(negedge clk);
    chk("halt_novalid", 32'(seen_valid), 0);
    chk("halt_pc_frozen", 32'(pc), 121);
    chk("halt_addr", 32'(iram_addr), 121);
    #2 rst = 1;
    #1;
    chk("halt_rst_pc", 32'(pc), 0);
    chk("halt_rst_halted", 32'(halted), 0);

    // async reset while presenting
    mem[0] = 8'd7; instr_ready = 0;
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("pres_valid", 32'(instr_valid), 1);
    #2 rst = 1;
    #1;
    chk("pres_rst_valid", 32'(instr_valid), 0);
    chk("pres_rst_instr", 32'(instr), 0);
    chk("pres_rst_pc", 32'(pc), 0);

    // async reset while resolving a jump operand
    mem[0] = 8'd29; mem[1] = 8'd50;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("opd_pc", 32'(pc), 1);
    #2 rst = 1;
    #1;
    chk("opd_rst_pc", 32'(pc), 0);
    chk("opd_rst_retired", 32'(retired), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("opd_restart_addr", 32'(iram_addr), 0);

    // pc wrap 255 -> 0 on a non-jump opcode
    rst = 1;
    mem[0] = 8'd29; mem[1] = 8'd255; mem[255] = 8'd7;
    instr_ready = 1; sb.push_back(8'd7);
    @(negedge clk);
    rst = 0;
    n = 0;
    while (!instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_timeout", 32'(n < 40), 1);
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_instr", 32'(instr), 7);
    @(negedge clk);
    chk("wrap_retired", 32'(retired), 2);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
